// File: rtl/mem_config_pkg.sv
// Shared configuration for the output memory path: address/data widths and
// the reader FSM state type.
package mem_config_pkg;

  localparam int unsigned ADDR_WIDTH = 6;
  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } reader_state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry buffer holding words returned by output_memory together with
// their end-of-frame flag until the stream sink accepts them.
module pixel_skid_fifo #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_last_o
);

  logic [DATA_WIDTH:0] entry_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;
  logic                push_ok;
  logic                pop_ok;

  assign full_o      = (count_q == 2'd2);
  assign empty_o     = (count_q == 2'd0);
  assign push_ok     = push_i && !full_o;
  assign pop_ok      = pop_i && !empty_o;
  assign head_data_o = entry_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign head_last_o = entry_q[rd_ptr_q][DATA_WIDTH];

  // Storage, pointers and occupancy; reset clears the entries so the head reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 2; i++) begin
        entry_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        entry_q[wr_ptr_q] <= {push_last_i, push_data_i};
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/output_memory_reader.sv
// Streams PIXELS words out of output_memory (synchronous read, one cycle
// latency) onto a valid/ready stream, flagging the last word.
// Optional macro OUT_READER_CLEAR_EN: write zero to each address as it is read.
module output_memory_reader
  import mem_config_pkg::*;
#(
  parameter int unsigned PIXELS = 2**ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_wr_en_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXELS - 1);

  reader_state_t         state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic [1:0]            occupancy;
  logic [1:0]            level;
  logic                  rd_issue;
  logic                  frame_end;

  // Occupancy after this cycle's pop plus the word still in the memory
  // pipeline must stay below two, otherwise the returning word has no slot.
  always_comb begin
    occupancy = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    pop       = !fifo_empty && m_ready_i;
    level     = occupancy - {1'b0, pop} + {1'b0, inflight_q};
    rd_issue  = (state_q == READ) && (level < 2'd2);
    frame_end = pop && m_last_o;
  end

  // Frame sequencing, address generation and in-flight read tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue && (addr_q == LAST_ADDR);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= READ;
            addr_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        READ: begin
          if (rd_issue) begin
            if (addr_q == LAST_ADDR) begin
              state_q <= DRAIN;
            end else begin
              addr_q <= addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (frame_end) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  pixel_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (inflight_q),
    .push_data_i(mem_data_i),
    .push_last_i(inflight_last_q),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_data_o(m_data_o),
    .head_last_o(m_last_o)
  );

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = '0;
  assign m_valid_o  = !fifo_empty;

`ifdef OUT_READER_CLEAR_EN
  assign mem_wr_en_o = rd_issue;
`else
  assign mem_wr_en_o = 1'b0;
`endif

endmodule

// File: tb/tb_output_memory_reader.sv
// Randomised self-checking bench for output_memory_reader: three instances
// (PIXELS = 16, 64, 1), each with its own read-first memory model.
module tb_output_memory_reader;
  import mem_config_pkg::*;

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_ready = 1'b0;
  logic start [3];

  logic                  busy   [3];
  logic                  done   [3];
  logic [ADDR_WIDTH-1:0] addr   [3];
  logic                  wr_en  [3];
  logic [DATA_WIDTH-1:0] wdata  [3];
  logic [DATA_WIDTH-1:0] rdata  [3];
  logic                  valid  [3];
  logic [DATA_WIDTH-1:0] data   [3];
  logic                  last   [3];

  logic [DATA_WIDTH-1:0] mem [3][DEPTH];
  logic                  load_req [3];
  int                    load_mode = 0;
  logic [DATA_WIDTH-1:0] load_val = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  output_memory_reader #(.PIXELS(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
    .mem_addr_o(addr[0]), .mem_wr_en_o(wr_en[0]), .mem_data_o(wdata[0]), .mem_data_i(rdata[0]),
    .m_valid_o(valid[0]), .m_ready_i(m_ready), .m_data_o(data[0]), .m_last_o(last[0]));

  output_memory_reader #(.PIXELS(64)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
    .mem_addr_o(addr[1]), .mem_wr_en_o(wr_en[1]), .mem_data_o(wdata[1]), .mem_data_i(rdata[1]),
    .m_valid_o(valid[1]), .m_ready_i(m_ready), .m_data_o(data[1]), .m_last_o(last[1]));

  output_memory_reader #(.PIXELS(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .busy_o(busy[2]), .done_o(done[2]),
    .mem_addr_o(addr[2]), .mem_wr_en_o(wr_en[2]), .mem_data_o(wdata[2]), .mem_data_i(rdata[2]),
    .m_valid_o(valid[2]), .m_ready_i(m_ready), .m_data_o(data[2]), .m_last_o(last[2]));

  // Read-first synchronous memories; preload requests rewrite the whole array.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (load_req[k]) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (load_mode == 0)      mem[k][i] <= DATA_WIDTH'(i);
          else if (load_mode == 1) mem[k][i] <= load_val;
          else                     mem[k][i] <= DATA_WIDTH'($urandom);
        end
      end else begin
        rdata[k] <= mem[k][addr[k]];
        if (wr_en[k]) mem[k][addr[k]] <= wdata[k];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_mem(input int k, input int mode, input logic [DATA_WIDTH-1:0] val);
    @(negedge clk);
    load_mode   = mode;
    load_val    = val;
    load_req[k] = 1'b1;
    @(negedge clk);
    load_req[k] = 1'b0;
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    check_eq({tag, "_ctl"}, {63'd0, busy[k] | done[k] | valid[k] | last[k] | wr_en[k]}, 64'd0);
    check_eq({tag, "_addr"}, 64'(addr[k]), 64'd0);
    check_eq({tag, "_data"}, 64'(data[k]), 64'd0);
  endtask

  // Runs one frame on instance k; the model is the memory image at start,
  // consumed in address order. abort_after>=0 stops after that many accepted words.
  task automatic run_frame(input int k, input int pixels, input int ready_pct,
                           input bit retrigger, input int abort_after);
    logic [DATA_WIDTH-1:0] exp_q [$];
    logic [DATA_WIDTH-1:0] snap [DEPTH];
    logic [DATA_WIDTH-1:0] hold_d;
    logic                  hold_l;
    logic [DATA_WIDTH-1:0] w;
    bit   stalled = 1'b0;
    bit   aborted = 1'b0;
    int   accepted = 0;
    int   done_cyc = -1;
    int   first_valid = -1;
    int   max_lead = 0;
    int   stall_err = 0;
    int   wr_cnt = 0;
    int   wdata_nz = 0;
    int   mem_bad = 0;
    int   idle_bad = 0;

    @(negedge clk);
    for (int i = 0; i < int'(DEPTH); i++) snap[i] = mem[k][i];
    for (int i = 0; i < pixels; i++) exp_q.push_back(snap[i]);
    start[k] = 1'b1;
    m_ready  = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);

    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      start[k] = (retrigger && cyc == 2);
      if (cyc == 1) begin
        check_eq("addr_first", 64'(addr[k]), 64'd0);
        check_eq("busy_after_start", 64'(busy[k]), 64'd1);
      end
      if (wr_en[k]) wr_cnt++;
      if (wdata[k] != '0) wdata_nz++;
      if (busy[k] && (int'(addr[k]) - accepted > max_lead)) max_lead = int'(addr[k]) - accepted;
      if (stalled && (!valid[k] || data[k] !== hold_d || last[k] !== hold_l)) stall_err++;
      if (valid[k] && first_valid < 0) first_valid = cyc;
      if (done[k]) begin
        done_cyc = cyc;
        break;
      end
      m_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      if (valid[k] && m_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_word", 64'(data[k]), 64'hx);
        end else begin
          w = exp_q.pop_front();
          check_eq("word", 64'(data[k]), 64'(w));
          check_eq("last_flag", 64'(last[k]), 64'(exp_q.size() == 0));
        end
        accepted++;
      end
      stalled = valid[k] && !m_ready;
      hold_d  = data[k];
      hold_l  = last[k];
      if (abort_after >= 0 && accepted == abort_after) begin
        aborted = 1'b1;
        break;
      end
    end
    start[k] = 1'b0;

    check_eq("stall_stable_errs", 64'(stall_err), 64'd0);
    check_eq("addr_lead_le2", 64'(max_lead <= 2), 64'd1);
    check_eq("wdata_zero", 64'(wdata_nz), 64'd0);
    if (!aborted) begin
      check_eq("done_seen", 64'(done_cyc > 0), 64'd1);
      check_eq("first_valid_cycle", 64'(first_valid), 64'd3);
      check_eq("words_accepted", 64'(accepted), 64'(pixels));
      check_eq("words_left", 64'(exp_q.size()), 64'd0);
      if (ready_pct >= 100) check_eq("done_latency", 64'(done_cyc), 64'(pixels + 3));
`ifdef OUT_READER_CLEAR_EN
      check_eq("wr_en_cycles", 64'(wr_cnt), 64'(pixels));
      for (int i = 0; i < pixels; i++) if (mem[k][i] != '0) mem_bad++;
`else
      check_eq("wr_en_cycles", 64'(wr_cnt), 64'd0);
      for (int i = 0; i < pixels; i++) if (mem[k][i] !== snap[i]) mem_bad++;
`endif
      check_eq("mem_after_frame", 64'(mem_bad), 64'd0);
      m_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (busy[k] || valid[k] || done[k]) idle_bad++;
      end
      check_eq("idle_after_done", 64'(idle_bad), 64'd0);
    end
  endtask

  initial begin
    int idle_bad;
    for (int k = 0; k < 3; k++) begin
      start[k]    = 1'b0;
      load_req[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs(0, "reset_a");
    check_idle_outputs(1, "reset_b");
    rst_n = 1'b1;

    // Ramp image, full-rate sink.
    load_mem(0, 0, '0);
    run_frame(0, 16, 100, 1'b0, -1);

    // Random image, sink ready ~30% and ~70% of cycles.
    load_mem(1, 2, '0);
    run_frame(1, 64, 30, 1'b0, -1);
    load_mem(1, 2, '0);
    run_frame(1, 64, 70, 1'b0, -1);

    // Single-word frame with a start pulse while busy.
    load_mem(2, 1, 8'hA5);
    run_frame(2, 1, 100, 1'b1, -1);
    run_frame(2, 1, 40, 1'b0, -1);

    // Reset after six words, then a fresh frame from address 0.
    load_mem(0, 0, '0);
    run_frame(0, 16, 100, 1'b0, 6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs(0, "midframe_reset");
    repeat (2) @(negedge clk);
    check_idle_outputs(0, "held_reset");
    rst_n = 1'b1;
    m_ready = 1'b1;
    idle_bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid[0] || busy[0]) idle_bad++;
    end
    check_eq("no_word_before_start", 64'(idle_bad), 64'd0);
    run_frame(0, 16, 100, 1'b0, -1);

    // All-FF image: stream FF, memory cleared only in clear-on-read builds.
    load_mem(0, 1, 8'hFF);
    run_frame(0, 16, 100, 1'b0, -1);
    load_mem(0, 1, 8'hFF);
    run_frame(0, 16, 50, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
